// File: rtl/adc_ltc2315_responder.sv
// LTC2315-style serial ADC responder: answers an SPI initiator with a
// leading zero, a DATA_BITS-wide sample MSB first, then zeros.
// cs/sck are asynchronous pins, synchronized into the clk_100 domain.
module adc_ltc2315_responder #(
  parameter int FRAME_SCK = 16,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk_100,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sck,
  output logic                 sdo,
  input  logic                 mode,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 underrun,
  output logic [15:0]          frame_count
);

  localparam int CW = $clog2(FRAME_SCK + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic                 cs_meta, cs_sync, cs_dly;
  logic                 sck_meta, sck_sync, sck_dly;
  logic                 armed;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] last_word;
  logic [DATA_BITS-1:0] ramp;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] frame_word;
  logic [CW-1:0]        rise_cnt;
  logic                 cs_rise, cs_fall, sck_rise, sck_fall;
  logic                 frame_start;

  assign cs_rise     = cs_sync & ~cs_dly;
  assign cs_fall     = ~cs_sync & cs_dly;
  assign sck_rise    = sck_sync & ~sck_dly;
  assign sck_fall    = ~sck_sync & sck_dly;
  assign frame_start = (state == IDLE) && cs_fall && armed;
  assign sample_ready = ~hold_full;

  // Word latched at frame start: ramp in mode 1, else the held sample,
  // falling back to repeating the previous word when nothing is held.
  assign frame_word = mode      ? ramp :
                      hold_full ? hold : last_word;

  // Two-flop synchronizers plus one edge-detect stage for cs and sck
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      {cs_meta, cs_sync, cs_dly}    <= '0;
      {sck_meta, sck_sync, sck_dly} <= '0;
    end else begin
      cs_meta  <= cs;
      cs_sync  <= cs_meta;
      cs_dly   <= cs_sync;
      sck_meta <= sck;
      sck_sync <= sck_meta;
      sck_dly  <= sck_sync;
    end
  end

  // Arm only after cs has been seen high, so a reset released with cs
  // low cannot start a frame halfway through the initiator's transfer
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset)        armed <= 1'b0;
    else if (cs_sync) armed <= 1'b1;
  end

  // Hold register: consumed by a mode-0 frame start; a load in that same
  // cycle is impossible when full, and lands for the next frame when empty
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (frame_start && !mode && hold_full) begin
      hold_full <= 1'b0;
    end else if (sample_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold      <= sample_in;
    end
  end

  // Frame FSM with registered sdo, status pulses and counters
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sdo         <= 1'b0;
      shreg       <= '0;
      rise_cnt    <= '0;
      last_word   <= '0;
      ramp        <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (frame_start) begin
            state     <= SHIFT;
            shreg     <= frame_word;
            last_word <= frame_word;
            rise_cnt  <= '0;
            underrun  <= ~mode & ~hold_full;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state       <= IDLE;
            sdo         <= 1'b0;
            frame_abort <= 1'b1;
          end else begin
            // Zeros shift in behind the data, so late falling edges emit 0
            if (sck_fall) begin
              sdo   <= shreg[DATA_BITS-1];
              shreg <= {shreg[DATA_BITS-2:0], 1'b0};
            end
            if (sck_rise) begin
              if (rise_cnt == CW'(FRAME_SCK - 1)) begin
                state <= DONE;
                sdo   <= 1'b0;
              end else begin
                rise_cnt <= rise_cnt + CW'(1);
              end
            end
          end
        end
        DONE: begin
          sdo <= 1'b0;
          if (cs_rise) begin
            state       <= IDLE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            ramp        <= ramp + DATA_BITS'(1);
          end
        end
        default: begin
          state <= IDLE;
          sdo   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ltc2315_responder.sv
// Bench for adc_ltc2315_responder: directed scenarios plus random frames,
// scored against a frame-level model. A second narrow instance (2-bit
// ramp) shares cs/sck so ramp wraparound is reached in a few frames.
module tb_adc_ltc2315_responder;

  localparam int FS  = 16;
  localparam int DB  = 12;
  localparam int SDB = 2;

  logic          clk_100 = 1'b0;
  logic          reset, cs, sck, mode, sample_valid;
  logic [DB-1:0] sample_in;
  logic          sdo, sample_ready, frame_done, frame_abort, underrun;
  logic [15:0]   frame_count;
  logic [SDB-1:0] s_sample_in = '0;
  logic          s_sdo, s_ready, s_done, s_abort, s_under;
  logic [15:0]   s_count;

  int n_chk = 0, n_fail = 0;
  int n_done = 0, n_abort = 0, n_under = 0, n_done_s = 0;

  // frame-level model state
  logic          m_full;
  logic [DB-1:0] m_hold, m_last, m_ramp;
  logic [15:0]   m_count;
  int            s_frames;

  always #5 clk_100 = ~clk_100;

  adc_ltc2315_responder #(.FRAME_SCK(FS), .DATA_BITS(DB)) dut (
    .clk_100(clk_100), .reset(reset), .cs(cs), .sck(sck), .sdo(sdo),
    .mode(mode), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .frame_done(frame_done),
    .frame_abort(frame_abort), .underrun(underrun), .frame_count(frame_count));

  adc_ltc2315_responder #(.FRAME_SCK(FS), .DATA_BITS(SDB)) dut_s (
    .clk_100(clk_100), .reset(reset), .cs(cs), .sck(sck), .sdo(s_sdo),
    .mode(1'b1), .sample_in(s_sample_in), .sample_valid(1'b0),
    .sample_ready(s_ready), .frame_done(s_done),
    .frame_abort(s_abort), .underrun(s_under), .frame_count(s_count));

  // pulse tallies, sampled away from the active edge
  always @(negedge clk_100) begin
    if (!reset) begin
      n_done   += int'(frame_done);
      n_abort  += int'(frame_abort);
      n_under  += int'(underrun);
      n_done_s += int'(s_done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_hold = '0; m_last = '0; m_ramp = '0;
    m_count = '0; s_frames = 0;
  endtask

  task automatic load_sample(input logic [DB-1:0] v);
    chk("ready_before_load", 32'(sample_ready), 32'(!m_full));
    @(negedge clk_100);
    sample_valid = 1'b1; sample_in = v;
    @(negedge clk_100);
    sample_valid = 1'b0;
    if (!m_full) begin m_full = 1'b1; m_hold = v; end
    chk("ready_after_load", 32'(sample_ready), 32'(0));
  endtask

  // Pin-level initiator: capture sdo just before each sck rise
  task automatic run_frame(input int n_rise, input bit coinc, input logic [DB-1:0] cval,
                           input logic nxt_mode, output logic [15:0] cb, output logic [15:0] cs_cap);
    cb = '0; cs_cap = '0;
    @(negedge clk_100);
    cs = 1'b0;
    @(posedge clk_100);
    @(posedge clk_100);
    @(negedge clk_100);
    if (coinc) begin sample_valid = 1'b1; sample_in = cval; end
    @(posedge clk_100);
    @(negedge clk_100);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk_100);
    for (int i = 0; i < n_rise; i++) begin
      if (i == 5) mode = nxt_mode;
      cb[15-i] = sdo; cs_cap[15-i] = s_sdo;
      sck = 1'b1;
      repeat (4) @(negedge clk_100);
      sck = 1'b0;
      repeat (4) @(negedge clk_100);
    end
    cs = 1'b1;
    repeat (6) @(negedge clk_100);
  endtask

  task automatic do_frame(input int n_rise, input bit coinc, input logic [DB-1:0] cval,
                          input logic nxt_mode);
    logic [DB-1:0] w;
    logic [15:0]   cb, csc, eb, es;
    bit            exp_under, was_full, complete;
    int            d0, a0, u0, sd0;
    d0 = n_done; a0 = n_abort; u0 = n_under; sd0 = n_done_s;
    complete  = (n_rise == FS);
    was_full  = m_full;
    exp_under = 1'b0;
    if (mode) w = m_ramp;
    else if (m_full) begin w = m_hold; m_full = 1'b0; end
    else begin w = m_last; exp_under = 1'b1; end
    m_last = w;
    if (coinc && !was_full) begin m_full = 1'b1; m_hold = cval; end
    eb = {1'b0, w, 3'b000};
    es = {1'b0, 2'(s_frames % 4), 13'd0};
    run_frame(n_rise, coinc, cval, nxt_mode, cb, csc);
    if (complete) begin
      chk("word", 32'(cb), 32'(eb));
      chk("word_small", 32'(csc), 32'(es));
      m_count++; m_ramp++; s_frames++;
    end else begin
      chk("word_prefix", 32'(cb >> (16 - n_rise)), 32'(eb >> (16 - n_rise)));
    end
    chk("done_pulses", 32'(n_done - d0), 32'(complete));
    chk("abort_pulses", 32'(n_abort - a0), 32'(!complete));
    chk("underrun_pulses", 32'(n_under - u0), 32'(exp_under));
    chk("frame_count", 32'(frame_count), 32'(m_count));
    chk("sdo_idle", 32'(sdo), 32'(0));
    chk("sample_ready", 32'(sample_ready), 32'(!m_full));
    chk("small_done", 32'(n_done_s - sd0), 32'(complete));
    chk("small_count", 32'(s_count), 32'(s_frames));
  endtask

  initial begin
    logic sdo_or;
    int   d0, a0;
    reset = 1'b1; cs = 1'b1; sck = 1'b0; mode = 1'b0;
    sample_valid = 1'b0; sample_in = '0;
    model_reset();
    repeat (3) @(negedge clk_100);
    chk("rst_sdo", 32'(sdo), 32'(0));
    chk("rst_ready", 32'(sample_ready), 32'(1));
    chk("rst_done", 32'(frame_done), 32'(0));
    chk("rst_abort", 32'(frame_abort), 32'(0));
    chk("rst_under", 32'(underrun), 32'(0));
    chk("rst_count", 32'(frame_count), 32'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk_100);

    // mode 0 basic word, then repeat on empty hold, then coincident load
    load_sample(12'hA5C);
    do_frame(FS, 1'b0, '0, 1'b0);
    load_sample(12'h123);
    do_frame(FS, 1'b0, '0, 1'b0);
    do_frame(FS, 1'b0, '0, 1'b0);
    do_frame(FS, 1'b1, 12'h7FF, 1'b0);
    do_frame(FS, 1'b0, '0, 1'b0);

    // short frame then a normal one
    load_sample(12'h3C9);
    do_frame(7, 1'b0, '0, 1'b0);
    load_sample(12'h5A6);
    do_frame(FS, 1'b0, '0, 1'b0);

    // reset mid-frame, released while cs still low
    @(negedge clk_100);
    cs = 1'b0;
    repeat (4) @(negedge clk_100);
    repeat (3) begin
      sck = 1'b1; repeat (4) @(negedge clk_100);
      sck = 1'b0; repeat (4) @(negedge clk_100);
    end
    reset = 1'b1;
    @(negedge clk_100);
    chk("midrst_sdo", 32'(sdo), 32'(0));
    chk("midrst_count", 32'(frame_count), 32'(0));
    repeat (2) @(negedge clk_100);
    reset = 1'b0;
    model_reset();
    d0 = n_done; a0 = n_abort; sdo_or = 1'b0;
    repeat (2) @(negedge clk_100);
    for (int i = 0; i < 10; i++) begin
      sdo_or |= sdo;
      sck = 1'b1; repeat (4) @(negedge clk_100);
      sdo_or |= sdo;
      sck = 1'b0; repeat (4) @(negedge clk_100);
    end
    cs = 1'b1;
    repeat (6) @(negedge clk_100);
    chk("postrst_sdo", 32'(sdo_or), 32'(0));
    chk("postrst_pulses", 32'((n_done - d0) + (n_abort - a0)), 32'(0));

    // mode 1 ramp from reset; small instance wraps 3 -> 0 on the 5th
    mode = 1'b1;
    repeat (5) do_frame(FS, 1'b0, '0, 1'b1);

    // randomized frames, with mode changed mid-frame
    for (int k = 0; k < 30; k++) begin
      logic          nm, coinc;
      logic [DB-1:0] v;
      int            nr;
      v = DB'($urandom);
      if (!m_full && $urandom_range(1, 0) == 1) load_sample(v);
      coinc = (!m_full && $urandom_range(3, 0) == 0);
      nr = ($urandom_range(4, 0) == 0) ? int'($urandom_range(FS - 1, 1)) : FS;
      nm = 1'($urandom);
      do_frame(nr, coinc, DB'($urandom), nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
